// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer_if
// Description : Handshake bundle between the game sequencer and its phase
//               engines: start/abort controls, per-phase done strobes, and the
//               registered enables, clear pulse, round and result flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_sequencer_if;
    // Controls and phase completion strobes (into the sequencer)
    logic       start;
    logic       abort;
    logic       gen_done;
    logic       disp_done;
    logic       wait_done;
    logic       check_done;
    logic       check_pass;

    // Registered sequencer outputs
    logic       gen_en;
    logic       disp_en;
    logic       wait_en;
    logic       check_en;
    logic       phase_clr;
    logic [3:0] round;
    logic [1:0] state_dbg;
    logic       win;
    logic       lose;

    // Driver side: supplies the controls, observes the sequencer
    modport master (
        output start, abort, gen_done, disp_done, wait_done, check_done, check_pass,
        input  gen_en, disp_en, wait_en, check_en, phase_clr, round, state_dbg, win, lose
    );

    // Sequencer side
    modport slave (
        input  start, abort, gen_done, disp_done, wait_done, check_done, check_pass,
        output gen_en, disp_en, wait_en, check_en, phase_clr, round, state_dbg, win, lose
    );
endinterface
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Top-level round sequencer for a memory game. Steps through
//               GEN -> DISP -> WAIT -> CHECK per round, with a WAIT-phase
//               inactivity timeout, sticky win/lose flags and a soft abort.
//               Every output is a flop; phase enables rise one cycle after a
//               one-cycle phase_clr pulse on each phase entry.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
    parameter int MAX_ROUND      = 16,
    parameter int TIMEOUT_CYCLES = 12000000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    game_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_READY = 3'd0,
        S_GEN   = 3'd1,
        S_DISP  = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } state_t;

    localparam logic [3:0]  LAST_ROUND   = 4'(MAX_ROUND - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic        start_q;
    logic [23:0] tmo_cnt_q;
    logic        gen_en_q;
    logic        disp_en_q;
    logic        wait_en_q;
    logic        check_en_q;
    logic        phase_clr_q;
    logic [3:0]  round_q;
    logic [1:0]  dbg_q;
    logic        win_q;
    logic        lose_q;

    logic        start_edge;
    logic        timeout_hit;
    logic        entry;

    // Phase code shown on state_dbg for the state being entered
    function automatic logic [1:0] phase_code(input state_t s);
        case (s)
            S_DISP:  return 2'b01;
            S_WAIT:  return 2'b10;
            S_CHECK: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // States that own an enable and get a phase_clr pulse on entry
    function automatic logic is_phase(input state_t s);
        return (s == S_GEN) || (s == S_DISP) || (s == S_WAIT) || (s == S_CHECK);
    endfunction

    assign start_edge  = bus.start & ~start_q;
    assign timeout_hit = (tmo_cnt_q == TIMEOUT_LAST);
    // No state ever transitions to itself, so any change of state is an entry
    assign entry       = (state_d != state_q);

    // Next-state decision; done strobes only count while their own enable is high
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_READY, S_WIN, S_LOSE: begin
                if (start_edge) state_d = S_GEN;
            end
            S_GEN: begin
                if (gen_en_q && bus.gen_done) state_d = S_DISP;
            end
            S_DISP: begin
                if (disp_en_q && bus.disp_done) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the final timeout cycle still wins
                if (wait_en_q) begin
                    if (bus.wait_done)     state_d = S_CHECK;
                    else if (timeout_hit)  state_d = S_LOSE;
                end
            end
            S_CHECK: begin
                if (check_en_q && bus.check_done) begin
                    if (!bus.check_pass)            state_d = S_LOSE;
                    else if (round_q == LAST_ROUND) state_d = S_WIN;
                    else                            state_d = S_DISP;
                end
            end
            default: state_d = S_READY;
        endcase
    end

    // State register plus all registered outputs, timeout counter and start copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_READY;
            start_q     <= 1'b1;
            tmo_cnt_q   <= 24'd0;
            gen_en_q    <= 1'b0;
            disp_en_q   <= 1'b0;
            wait_en_q   <= 1'b0;
            check_en_q  <= 1'b0;
            phase_clr_q <= 1'b0;
            round_q     <= 4'd0;
            dbg_q       <= 2'b00;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else if (bus.abort) begin
            // Soft reset; the start copy keeps tracking so a held button needs a fresh edge
            state_q     <= S_READY;
            start_q     <= bus.start;
            tmo_cnt_q   <= 24'd0;
            gen_en_q    <= 1'b0;
            disp_en_q   <= 1'b0;
            wait_en_q   <= 1'b0;
            check_en_q  <= 1'b0;
            phase_clr_q <= 1'b0;
            round_q     <= 4'd0;
            dbg_q       <= 2'b00;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            start_q <= bus.start;
            state_q <= state_d;

            if (entry) begin
                // First cycle of a new state: clear pulse, enables held low
                phase_clr_q <= is_phase(state_d);
                gen_en_q    <= 1'b0;
                disp_en_q   <= 1'b0;
                wait_en_q   <= 1'b0;
                check_en_q  <= 1'b0;
                dbg_q       <= phase_code(state_d);
            end else begin
                phase_clr_q <= 1'b0;
                gen_en_q    <= (state_q == S_GEN);
                disp_en_q   <= (state_q == S_DISP);
                wait_en_q   <= (state_q == S_WAIT);
                check_en_q  <= (state_q == S_CHECK);
            end

            if (entry && (state_d == S_GEN)) begin
                round_q <= 4'd0;
                win_q   <= 1'b0;
                lose_q  <= 1'b0;
            end
            if (entry && (state_d == S_WIN))  win_q  <= 1'b1;
            if (entry && (state_d == S_LOSE)) lose_q <= 1'b1;

            // Only a passing check that is not the last round advances the round
            if ((state_q == S_CHECK) && (state_d == S_DISP)) round_q <= round_q + 4'd1;

            if (entry && (state_d == S_WAIT)) tmo_cnt_q <= 24'd0;
            else if (wait_en_q)               tmo_cnt_q <= tmo_cnt_q + 24'd1;
        end
    end

    assign bus.gen_en    = gen_en_q;
    assign bus.disp_en   = disp_en_q;
    assign bus.wait_en   = wait_en_q;
    assign bus.check_en  = check_en_q;
    assign bus.phase_clr = phase_clr_q;
    assign bus.round     = round_q;
    assign bus.state_dbg = dbg_q;
    assign bus.win       = win_q;
    assign bus.lose      = lose_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Self-checking bench for game_sequencer. Games are played as
//               transactions: a per-game plan (failing round, timeout round,
//               WAIT latency) predicts the phase order, round values and the
//               final win/lose result. Idle done strobes and start toggles are
//               randomized to show they are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    localparam int MAXR = 4;
    localparam int TOUT = 10;

    logic clk = 1'b0;
    logic rst_n;

    game_sequencer_if bus();

    game_sequencer #(
        .MAX_ROUND      (MAXR),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [3:0] en_vec();
        return {bus.check_en, bus.wait_en, bus.disp_en, bus.gen_en};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Randomize strobes of the other phases; start toggles only in GEN/DISP
    task automatic noise(input int p, input logic own);
        logic [3:0] r;
        r = 4'($urandom);
        r[p] = own;
        bus.gen_done   = r[0];
        bus.disp_done  = r[1];
        bus.wait_done  = r[2];
        bus.check_done = r[3];
        bus.check_pass = 1'($urandom);
        bus.start      = (p <= 1) ? 1'($urandom) : 1'b0;
    endtask

    // Entry cycle: clear pulse with enable low, then enable high with clear low
    task automatic phase_enter(input int p, input logic [3:0] r);
        checks++;
        if (bus.phase_clr !== 1'b1 || en_vec() !== 4'b0000 || bus.state_dbg !== 2'(p) ||
            bus.round !== r || bus.win !== 1'b0 || bus.lose !== 1'b0) begin
            errors++;
            $display("FAIL phase_entry p=%0d: clr=%b en=%b dbg=%0d round=%0d win=%b lose=%b; required clr=1 en=0000 dbg=%0d round=%0d win=0 lose=0",
                     p, bus.phase_clr, en_vec(), bus.state_dbg, bus.round, bus.win, bus.lose, p, r);
        end
        noise(p, 1'($urandom));
        step();
        checks++;
        if (bus.phase_clr !== 1'b0 || en_vec() !== 4'(1 << p) || bus.state_dbg !== 2'(p)) begin
            errors++;
            $display("FAIL phase_enable p=%0d: clr=%b en=%b dbg=%0d; required clr=0 en=%b dbg=%0d",
                     p, bus.phase_clr, en_vec(), bus.state_dbg, 4'(1 << p), p);
        end
        noise(p, 1'b0);
    endtask

    task automatic hold_phase(input int p, input logic [3:0] r, input int d);
        phase_enter(p, r);
        for (int i = 0; i < d; i++) begin
            step();
            checks++;
            if (en_vec() !== 4'(1 << p) || bus.phase_clr !== 1'b0) begin
                errors++;
                $display("FAIL phase_hold p=%0d: en=%b clr=%b; required en=%b clr=0",
                         p, en_vec(), bus.phase_clr, 4'(1 << p));
            end
            noise(p, 1'b0);
        end
    endtask

    // One full game from a start edge; fail_at/tout_at pick the ending round
    task automatic play_game(input int fail_at, input int tout_at, input int wlat);
        int   r;
        bit   over;
        logic exp_win;
        int   lat;
        logic pass;
        r = 0; over = 0; exp_win = 1'b0;
        bus.abort = 1'b0;
        bus.start = 1'b0; step();
        bus.start = 1'b1; step();
        hold_phase(0, 4'd0, $urandom_range(0, 3));
        bus.gen_done = 1'b1; step();
        while (!over) begin
            hold_phase(1, 4'(r), $urandom_range(0, 3));
            bus.disp_done = 1'b1; step();
            phase_enter(2, 4'(r));
            if (r == tout_at)  lat = TOUT + $urandom_range(0, 2);
            else if (wlat >= 0) lat = wlat;
            else               lat = $urandom_range(0, TOUT - 1);
            for (int k = 0; k < TOUT; k++) begin
                checks++;
                if (en_vec() !== 4'b0100 || bus.lose !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_cycle k=%0d: en=%b lose=%b; required en=0100 lose=0",
                             k, en_vec(), bus.lose);
                end
                if (k == lat) bus.wait_done = 1'b1;
                else          noise(2, 1'b0);
                step();
                if (k == lat) break;
            end
            if (lat >= TOUT) begin
                over = 1; exp_win = 1'b0;
            end else begin
                hold_phase(3, 4'(r), $urandom_range(0, 3));
                pass = (r != fail_at);
                bus.check_done = 1'b1;
                bus.check_pass = pass;
                step();
                if (!pass)                begin over = 1; exp_win = 1'b0; end
                else if (r == MAXR - 1)   begin over = 1; exp_win = 1'b1; end
                else                      r++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.win !== exp_win || bus.lose !== ~exp_win || en_vec() !== 4'b0000 ||
                bus.phase_clr !== 1'b0 || bus.state_dbg !== 2'b00 || bus.round !== 4'(r)) begin
                errors++;
                $display("FAIL game_result: win=%b lose=%b en=%b clr=%b dbg=%0d round=%0d; required win=%b lose=%b en=0000 clr=0 dbg=0 round=%0d",
                         bus.win, bus.lose, en_vec(), bus.phase_clr, bus.state_dbg, bus.round,
                         exp_win, ~exp_win, r);
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1; bus.abort = 1'b0;
        bus.gen_done = 1'b0; bus.disp_done = 1'b0; bus.wait_done = 1'b0;
        bus.check_done = 1'b0; bus.check_pass = 1'b0;
        repeat (3) step();
        checks++;
        if (en_vec() !== 4'b0000 || bus.phase_clr !== 1'b0 || bus.round !== 4'd0 ||
            bus.state_dbg !== 2'b00 || bus.win !== 1'b0 || bus.lose !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: en=%b clr=%b round=%0d dbg=%0d win=%b lose=%b; required all zero",
                     en_vec(), bus.phase_clr, bus.round, bus.state_dbg, bus.win, bus.lose);
        end
        rst_n = 1'b1;
        // start held high through reset must not start a game
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (en_vec() !== 4'b0000 || bus.phase_clr !== 1'b0 || bus.state_dbg !== 2'b00) begin
                errors++;
                $display("FAIL held_start_ignored: en=%b clr=%b dbg=%0d; required en=0000 clr=0 dbg=0",
                         en_vec(), bus.phase_clr, bus.state_dbg);
            end
        end
        bus.start = 1'b0; step();
        bus.start = 1'b1; step();
        phase_enter(0, 4'd0);
        bus.abort = 1'b1; step();
        bus.abort = 1'b0;
        checks++;
        if (en_vec() !== 4'b0000 || bus.phase_clr !== 1'b0 || bus.state_dbg !== 2'b00) begin
            errors++;
            $display("FAIL abort_in_gen: en=%b clr=%b dbg=%0d; required en=0000 clr=0 dbg=0",
                     en_vec(), bus.phase_clr, bus.state_dbg);
        end
    endtask

    task automatic test_abort();
        bus.start = 1'b0; step();
        bus.start = 1'b1; step();
        hold_phase(0, 4'd0, 1);
        bus.gen_done = 1'b1; step();
        bus.gen_done = 1'b0;
        // DISP entry cycle: disp_en is 0, so this disp_done must be ignored
        bus.disp_done = 1'b1; step();
        bus.disp_done = 1'b0;
        checks++;
        if (en_vec() !== 4'b0010 || bus.state_dbg !== 2'b01) begin
            errors++;
            $display("FAIL disp_done_ignored: en=%b dbg=%0d; required en=0010 dbg=1",
                     en_vec(), bus.state_dbg);
        end
        bus.disp_done = 1'b1; step();
        bus.disp_done = 1'b0;
        phase_enter(2, 4'd0);
        bus.wait_done = 1'b1;
        bus.abort     = 1'b1;
        step();
        bus.wait_done = 1'b0;
        bus.abort     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (en_vec() !== 4'b0000 || bus.phase_clr !== 1'b0 || bus.round !== 4'd0 ||
                bus.state_dbg !== 2'b00 || bus.win !== 1'b0 || bus.lose !== 1'b0) begin
                errors++;
                $display("FAIL abort_in_wait: en=%b clr=%b round=%0d dbg=%0d win=%b lose=%b; required all zero",
                         en_vec(), bus.phase_clr, bus.round, bus.state_dbg, bus.win, bus.lose);
            end
            step();
        end
    endtask

    task automatic test_fail_last_round();
        play_game(3, -1, -1);
        play_game(-1, -1, -1);
    endtask

    task automatic test_timeout();
        play_game(-1, 0, -1);
        play_game(-1, -1, TOUT - 1);
        play_game(-1, 2, TOUT - 1);
    endtask

    task automatic test_random_games();
        for (int g = 0; g < 12; g++) begin
            play_game($urandom_range(0, 2 * MAXR), $urandom_range(0, 2 * MAXR), -1);
        end
    endtask

    initial begin
        test_reset();
        test_fail_last_round();
        test_timeout();
        test_abort();
        test_random_games();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
